// File: rtl/uart_rx_oversample.sv
// 8N1 serial receiver with 16x oversampling, a two-flop input synchroniser, and a free-running
// baud tick. Each good byte gets a one-cycle done strobe; a bad stop bit raises a frame error.
`timescale 1ns / 1ps
module uart_rx_oversample #(
  parameter int unsigned DBITS    = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned BAUD_DIV = 651
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  output logic [DBITS-1:0] dout,
  output logic             rx_done_tick,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned NW   = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);
  localparam logic [NW-1:0]   NMax   = NW'(DBITS - 1);
  localparam logic [3:0]      SbMax  = 4'(SB_TICK - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic            rx_meta_q, rx_sync_q;
  logic [CntW-1:0] cnt_q;
  logic            s_tick;
  state_e          state_q;
  logic [3:0]      s_q;
  logic [NW-1:0]   n_q;
  logic [DBITS-1:0] b_q, dout_q;
  logic            done_q, ferr_q, busy_q;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Free-running so the sampling phase error stays within one tick.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign s_tick = (cnt_q == CntMax);

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            state_q <= StStart;
            s_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (s_tick) begin
            if (s_q == 4'd7) begin
              if (rx_sync_q) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                state_q <= StData;
                s_q     <= '0;
                n_q     <= '0;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        StData: begin
          if (s_tick) begin
            if (s_q == 4'd15) begin
              b_q <= {rx_sync_q, b_q[DBITS-1:1]};
              s_q <= '0;
              if (n_q == NMax) begin
                state_q <= StStop;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        StStop: begin
          if (s_tick) begin
            if (s_q == SbMax) begin
              if (rx_sync_q) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                dout_q  <= b_q;
                done_q  <= 1'b1;
              end else begin
                state_q <= StBreak;
                ferr_q  <= 1'b1;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        StBreak: begin
          if (rx_sync_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: serial frames driven on rx, expected bytes queued on send and
// matched against each rx_done_tick.
`timescale 1ns / 1ps
module tb_uart_rx_oversample;

  localparam int unsigned Baud = 4;
  localparam int          Bit  = 16 * Baud;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick, frame_err, busy;

  logic [7:0] sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  logic prev_pulse = 1'b0;

  uart_rx_oversample #(
    .DBITS   (8),
    .SB_TICK (16),
    .BAUD_DIV(Baud)
  ) dut (
    .clk_100MHz  (clk),
    .reset       (rst_n),
    .rx          (rx),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int bit_clks, input logic stop_lvl);
    logic [9:0] fr;
    fr = {stop_lvl, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (bit_clks) @(negedge clk);
    end
  endtask

  task automatic idle(input int clks);
    rx = 1'b1;
    repeat (clks) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else check("dout", dout, sb_q.pop_front());
    end
    if (frame_err) ferr_cnt++;
    if (rx_done_tick || frame_err) begin
      check("excl", rx_done_tick & frame_err, 0);
      check("pulse_len", prev_pulse, 0);
    end
    prev_pulse = rx_done_tick | frame_err;
  end

  initial begin
    logic [7:0] part;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_done", rx_done_tick, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2 * Bit);

    // Single frame
    sb_q.push_back(8'h41);
    send_frame(8'h41, Bit, 1'b1);
    idle(2 * Bit);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_ferr_cnt", ferr_cnt, 0);
    check("t1_busy", busy, 0);
    check("t1_dout", dout, 8'h41);

    // Back-to-back, no idle gap
    sb_q.push_back(8'h55);
    send_frame(8'h55, Bit, 1'b1);
    sb_q.push_back(8'hAA);
    send_frame(8'hAA, Bit, 1'b1);
    idle(2 * Bit);
    check("t2_done_cnt", done_cnt, 3);
    check("t2_dout", dout, 8'hAA);

    // Short low glitch is rejected
    rx = 1'b0;
    repeat (18) @(negedge clk);
    idle(2 * Bit);
    check("t3_done_cnt", done_cnt, 3);
    check("t3_busy", busy, 0);
    check("t3_dout", dout, 8'hAA);

    // Low stop bit, line held low for three bit times
    send_frame(8'h3C, Bit, 1'b0);
    repeat (2 * Bit) @(negedge clk);
    check("t4_ferr_cnt", ferr_cnt, 1);
    check("t4_busy_break", busy, 1);
    check("t4_done_cnt", done_cnt, 3);
    check("t4_dout", dout, 8'hAA);
    idle(8);
    check("t4_busy_idle", busy, 0);
    idle(Bit);
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, Bit, 1'b1);
    idle(2 * Bit);
    check("t4_good_cnt", done_cnt, 4);
    check("t4_ferr_once", ferr_cnt, 1);

    // Reset in the middle of bit 4
    part = 8'h99;
    rx = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      repeat (Bit) @(negedge clk);
    end
    rx = part[4];
    repeat (Bit / 2) @(negedge clk);
    check("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_dout", dout, 0);
    check("t5_done", rx_done_tick, 0);
    check("t5_ferr", frame_err, 0);
    check("t5_busy", busy, 0);
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * Bit);
    check("t5_busy_after", busy, 0);
    sb_q.push_back(8'h7E);
    send_frame(8'h7E, Bit, 1'b1);
    idle(2 * Bit);
    check("t5_done_cnt", done_cnt, 5);
    check("t5_dout_7e", dout, 8'h7E);

    // +/-3% bit period skew
    sb_q.push_back(8'hC3);
    send_frame(8'hC3, Bit + 2, 1'b1);
    idle(2 * Bit);
    check("t6_fast_dout", dout, 8'hC3);
    dut_clear_dout();
    sb_q.push_back(8'hC3);
    send_frame(8'hC3, Bit - 2, 1'b1);
    idle(2 * Bit);
    check("t6_slow_dout", dout, 8'hC3);
    check("t6_done_cnt", done_cnt, 8);
    check("t6_ferr_cnt", ferr_cnt, 1);
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Receive a different byte between the two skewed 0xC3 frames so the second one is observable.
  task automatic dut_clear_dout();
    sb_q.push_back(8'h00);
    send_frame(8'h00, Bit, 1'b1);
    idle(2 * Bit);
    check("t6_clear_dout", dout, 8'h00);
  endtask

endmodule
